// File: rtl/alu_exec_stage.sv
// Issue/capture stage for an external 8-bit combinational ALU: registers operands,
// queues ALU results in an in-order FIFO and cross-checks them against a reference model.
`timescale 1ns/1ps
module alu_exec_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opcode,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_mismatch,
    output logic             err_sticky,
    output logic [7:0]       err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 8 + 1 + 1 + TAG_W + 1;
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Returns {carry, result} of the lockstep reference ALU.
    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {(a < b), a - b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_NOT:  r = {1'b0, ~a};
            OP_SHL:  r = {a[7], a[6:0], 1'b0};
            OP_SHR:  r = {a[0], 1'b0, a[7:1]};
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [7:0]       s1_a_q, s1_a_d;
    logic [7:0]       s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             err_sticky_q, err_sticky_d;
    logic [7:0]       err_count_q, err_count_d;

    logic             pop_s, push_s, accept_s, full_s, mismatch_s, ref_zero_s;
    logic [8:0]       ref_s;
    logic [ENT_W-1:0] head_s, entry_s;

    assign full_s     = (count_q == DEPTH_C);
    assign rsp_valid  = (count_q != {(PTR_W+1){1'b0}});
    assign pop_s      = rsp_valid && rsp_ready;
    assign push_s     = s1_valid_q && (!full_s || pop_s);
    assign req_ready  = !s1_valid_q || push_s;
    assign accept_s   = req_valid && req_ready;

    assign ref_s      = ref_alu(s1_op_q, s1_a_q, s1_b_q);
    assign ref_zero_s = (ref_s[7:0] == 8'd0);
    assign mismatch_s = (alu_out != ref_s[7:0]) || (alu_carry != ref_s[8]) ||
                        (alu_zero != ref_zero_s);
    assign entry_s    = {mismatch_s, s1_tag_q, alu_zero, alu_carry, alu_out};

    assign alu_a      = s1_a_q;
    assign alu_b      = s1_b_q;
    assign alu_opcode = s1_op_q;

    assign head_s       = mem_q[rd_ptr_q];
    assign rsp_result   = rsp_valid ? head_s[7:0] : 8'd0;
    assign rsp_carry    = rsp_valid ? head_s[8] : 1'b0;
    assign rsp_zero     = rsp_valid ? head_s[9] : 1'b0;
    assign rsp_tag      = rsp_valid ? head_s[10 +: TAG_W] : {TAG_W{1'b0}};
    assign rsp_mismatch = rsp_valid ? head_s[ENT_W-1] : 1'b0;
    assign err_sticky   = err_sticky_q;
    assign err_count    = err_count_q;

    // S1 next state: load on accept, retire on advance, otherwise hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_op_d    = req_opcode;
            s1_a_d     = req_a;
            s1_b_d     = req_b;
            s1_tag_d   = req_tag;
        end else if (push_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // FIFO pointer/occupancy and error counter next state.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (push_s && mismatch_s) begin
            err_sticky_d = 1'b1;
            err_count_d  = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= 3'd0;
            s1_a_q       <= 8'd0;
            s1_b_q       <= 8'd0;
            s1_tag_q     <= {TAG_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {(PTR_W+1){1'b0}};
            err_sticky_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_tag_q     <= s1_tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    // FIFO storage; captures the ALU values, never the reference values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule
